buck_pwm_gen: RTL

Two-phase interleaved buck gate-drive generator. Runs the free-running 4 µs switching timer whose phase-0 value feeds the one-cycle controller's `timer_buck_4us_0`. Consumes the controller's `inductor_charging_time` and produces high-side and low-side gate commands for both channels, with:

- dead-time insertion,
- duty clamping,
- a sticky fault shutdown.

Channel 1 runs 180° out of phase with channel 0.

---
 rtl/buck_pkg.sv | 25 ++
 rtl/buck_pwm_channel.sv | 98 +++++++++
 rtl/buck_pwm_gen.sv | 101 ++++++++++
 3 files changed

// File: rtl/buck_pkg.sv
// Shared types and default constants for the two-phase interleaved buck gate-drive generator.
package buck_pkg;

    localparam int unsigned TIMER_W          = 16;
    localparam int unsigned PERIOD_DEF       = 400;
    localparam int unsigned PHASE_OFFSET_DEF = 200;
    localparam int unsigned MAX_ON_DEF       = 200;
    localparam int unsigned MIN_ON_DEF       = 4;
    localparam int unsigned DEAD_DEF         = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DT_PRE,
        ST_HIGH,
        ST_DT_POST,
        ST_LOW
    } chan_state_t;

    // Requested on-time limited to the maximum high-side width.
    function automatic logic [TIMER_W-1:0] clamp_on(input logic [TIMER_W-1:0] req,
                                                    input int unsigned        max_on);
        return (req > TIMER_W'(max_on)) ? TIMER_W'(max_on) : req;
    endfunction

endpackage

// File: rtl/buck_pwm_channel.sv
// One buck phase: shadow duty register, dead-time counter and HS/LS sequencing FSM.
module buck_pwm_channel
    import buck_pkg::*;
#(
    parameter int unsigned MAX_ON = MAX_ON_DEF,
    parameter int unsigned MIN_ON = MIN_ON_DEF,
    parameter int unsigned DEAD   = DEAD_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [TIMER_W-1:0] i_timer,
    input  logic [TIMER_W-1:0] i_duty,
    input  logic               i_enable,
    input  logic               i_force_off,
    output logic               o_hs,
    output logic               o_ls
);

    chan_state_t        r_state;
    logic [TIMER_W-1:0] r_cnt;
    logic [TIMER_W-1:0] r_duty;
    logic               r_hs;
    logic               r_ls;

    logic [TIMER_W-1:0] w_clamp;
    logic               w_start;

    assign w_clamp = clamp_on(i_duty, MAX_ON);
    assign w_start = (i_timer == '0);

    // Gates are registered from the next state, so they lag the timer by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_duty  <= '0;
            r_hs    <= 1'b0;
            r_ls    <= 1'b0;
        end else begin
            r_hs <= 1'b0;
            r_ls <= 1'b0;
            if (w_start) begin
                r_duty <= w_clamp;
            end
            if (!i_enable || i_force_off) begin
                r_state <= ST_IDLE;
            end else if (w_start) begin
                if (w_clamp >= TIMER_W'(MIN_ON)) begin
                    r_state <= ST_DT_PRE;
                    r_cnt   <= TIMER_W'(1);
                end else begin
                    r_state <= ST_LOW;
                    r_ls    <= 1'b1;
                end
            end else begin
                // r_cnt holds the number of cycles already spent in the current state.
                case (r_state)
                    ST_DT_PRE: begin
                        if (r_cnt >= TIMER_W'(DEAD)) begin
                            r_state <= ST_HIGH;
                            r_cnt   <= TIMER_W'(1);
                            r_hs    <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + TIMER_W'(1);
                        end
                    end
                    ST_HIGH: begin
                        if (r_cnt >= r_duty) begin
                            r_state <= ST_DT_POST;
                            r_cnt   <= TIMER_W'(1);
                        end else begin
                            r_cnt <= r_cnt + TIMER_W'(1);
                            r_hs  <= 1'b1;
                        end
                    end
                    ST_DT_POST: begin
                        if (r_cnt >= TIMER_W'(DEAD)) begin
                            r_state <= ST_LOW;
                            r_ls    <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + TIMER_W'(1);
                        end
                    end
                    ST_LOW: begin
                        r_ls <= 1'b1;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_hs = r_hs;
    assign o_ls = r_ls;

endmodule

// File: rtl/buck_pwm_gen.sv
// Two-phase interleaved buck gate-drive generator: 4 us period timers, fault latch, two channels 180 deg apart.
module buck_pwm_gen
    import buck_pkg::*;
#(
    parameter int unsigned PERIOD       = PERIOD_DEF,
    parameter int unsigned PHASE_OFFSET = PHASE_OFFSET_DEF,
    parameter int unsigned MAX_ON       = MAX_ON_DEF,
    parameter int unsigned MIN_ON       = MIN_ON_DEF,
    parameter int unsigned DEAD         = DEAD_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               fault,
    input  logic [TIMER_W-1:0] inductor_charging_time,
    output logic [TIMER_W-1:0] timer_buck_4us_0,
    output logic [TIMER_W-1:0] timer_buck_4us_180,
    output logic [1:0]         hs_gate,
    output logic [1:0]         ls_gate,
    output logic [TIMER_W-1:0] on_time_applied,
    output logic               fault_latched
);

    logic [TIMER_W-1:0] r_t0;
    logic [TIMER_W-1:0] r_t180;
    logic [TIMER_W-1:0] r_on_time;
    logic               r_fault_latched;

    logic [TIMER_W-1:0] w_t0_next;
    logic [TIMER_W:0]   w_sum;
    logic [TIMER_W-1:0] w_t180_next;
    logic               w_force_off;
    logic [1:0]         w_hs;
    logic [1:0]         w_ls;

    assign w_t0_next   = (r_t0 == TIMER_W'(PERIOD - 1)) ? '0 : r_t0 + TIMER_W'(1);
    assign w_sum       = {1'b0, w_t0_next} + (TIMER_W+1)'(PHASE_OFFSET);
    assign w_t180_next = (w_sum >= (TIMER_W+1)'(PERIOD)) ? TIMER_W'(w_sum - (TIMER_W+1)'(PERIOD))
                                                         : TIMER_W'(w_sum);
    // A fault in this cycle must already kill the gates at the next edge.
    assign w_force_off = fault | r_fault_latched;

    // Free-running timers, applied on-time and sticky fault flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_t0            <= '0;
            r_t180          <= '0;
            r_on_time       <= '0;
            r_fault_latched <= 1'b0;
        end else begin
            r_t0   <= w_t0_next;
            r_t180 <= w_t180_next;
            if (r_t0 == '0) begin
                r_on_time <= clamp_on(inductor_charging_time, MAX_ON);
            end
            if (fault) begin
                r_fault_latched <= 1'b1;
            end else if (!enable) begin
                r_fault_latched <= 1'b0;
            end
        end
    end

    buck_pwm_channel #(
        .MAX_ON (MAX_ON),
        .MIN_ON (MIN_ON),
        .DEAD   (DEAD)
    ) u_ch0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_timer     (r_t0),
        .i_duty      (inductor_charging_time),
        .i_enable    (enable),
        .i_force_off (w_force_off),
        .o_hs        (w_hs[0]),
        .o_ls        (w_ls[0])
    );

    buck_pwm_channel #(
        .MAX_ON (MAX_ON),
        .MIN_ON (MIN_ON),
        .DEAD   (DEAD)
    ) u_ch1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_timer     (r_t180),
        .i_duty      (inductor_charging_time),
        .i_enable    (enable),
        .i_force_off (w_force_off),
        .o_hs        (w_hs[1]),
        .o_ls        (w_ls[1])
    );

    assign timer_buck_4us_0   = r_t0;
    assign timer_buck_4us_180 = r_t180;
    assign hs_gate            = w_hs;
    assign ls_gate            = w_ls;
    assign on_time_applied    = r_on_time;
    assign fault_latched      = r_fault_latched;

endmodule
